// File: rtl/comm_parallel_regs.sv
// comm_parallel_regs
//   Register slave for an asynchronous parallel bus driven from board pins.
//   The write/read strobes are brought into the clk domain through two-flop
//   synchronisers. A four-phase handshake then writes into a NUM_REGS-deep
//   register bank, or reads from that bank or from a read-only status word.
//   The status word sits at BASE_ADDR+NUM_REGS.
//
// Ports
//   clk, rstN            system clock; asynchronous active-low reset
//   inData, addr         write data / address from the master (async pins)
//   writeData, readData  async write / read strobes
//   outData, outEn       read data and its pad drive enable
//   ack                  handshake acknowledge
//   statusIn             read-only status word
//   regOut               bank contents, reg k at [k*DATA_W +: DATA_W]
//   regWe                one-cycle pulse on the register just written
//   addrErr              sticky flag: last completed access was out of range
//   errCnt               saturating count of both-strobes-high errors
module comm_parallel_regs #(
  parameter int DATA_W    = 4,
  parameter int ADDR_W    = 8,
  parameter int NUM_REGS  = 16,
  parameter int BASE_ADDR = 0
) (
  input  logic                         clk,
  input  logic                         rstN,
  input  logic [DATA_W-1:0]            inData,
  input  logic [ADDR_W-1:0]            addr,
  input  logic                         writeData,
  input  logic                         readData,
  output logic [DATA_W-1:0]            outData,
  output logic                         outEn,
  output logic                         ack,
  input  logic [DATA_W-1:0]            statusIn,
  output logic [NUM_REGS*DATA_W-1:0]   regOut,
  output logic [NUM_REGS-1:0]          regWe,
  output logic                         addrErr,
  output logic [7:0]                   errCnt
);

  // One extra bit so BASE_ADDR+NUM_REGS never wraps in the range compare.
  localparam logic [ADDR_W:0] BASE_X = (ADDR_W+1)'(BASE_ADDR);
  localparam logic [ADDR_W:0] LAST_X = (ADDR_W+1)'(BASE_ADDR + NUM_REGS);
  localparam logic [ADDR_W:0] NREG_X = (ADDR_W+1)'(NUM_REGS);

  typedef enum logic [1:0] {IDLE, WR_ACK, RD_ACK, ERR_WAIT} state_t;

  state_t              state;
  logic                wr_p0, wr_s;
  logic                rd_p0, rd_s;
  logic [ADDR_W:0]     addr_x;
  logic [ADDR_W:0]     off_x;
  logic                in_range;
  logic                is_stat;
  logic [NUM_REGS-1:0] hit_vec;
  logic [DATA_W-1:0]   rd_val;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Stage p0/p1: two-flop strobe synchronisers
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      wr_p0 <= 1'b0;
      wr_s  <= 1'b0;
      rd_p0 <= 1'b0;
      rd_s  <= 1'b0;
    end else begin
      wr_p0 <= writeData;
      wr_s  <= wr_p0;
      rd_p0 <= readData;
      rd_s  <= rd_p0;
    end
  end

  // Address decode straight from the pins; the result is consumed only on
  // the IDLE exit edge, by which time the master holds addr stable.
  assign addr_x   = {1'b0, addr};
  assign off_x    = addr_x - BASE_X;
  assign in_range = (addr_x >= BASE_X) && (addr_x <= LAST_X);
  assign is_stat  = in_range && (off_x == NREG_X);

  always_comb begin
    hit_vec = '0;
    rd_val  = '0;
    if (is_stat) rd_val = statusIn;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (in_range && (off_x == (ADDR_W+1)'(k))) begin
        hit_vec[k] = 1'b1;
        rd_val     = regOut[k*DATA_W +: DATA_W];
      end
    end
  end

  // Stage p2: handshake FSM, register bank and registered outputs
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state   <= IDLE;
      outData <= '0;
      outEn   <= 1'b0;
      ack     <= 1'b0;
      regOut  <= '0;
      regWe   <= '0;
      addrErr <= 1'b0;
      errCnt  <= '0;
    end else begin
      regWe <= '0;
      case (state)
        IDLE: begin
          if (wr_s && !rd_s) begin
            for (int k = 0; k < NUM_REGS; k++)
              if (hit_vec[k]) regOut[k*DATA_W +: DATA_W] <= inData;
            regWe   <= hit_vec;
            addrErr <= !in_range;
            ack     <= 1'b1;
            state   <= WR_ACK;
          end else if (rd_s && !wr_s) begin
            outData <= rd_val;
            outEn   <= 1'b1;
            addrErr <= !in_range;
            ack     <= 1'b1;
            state   <= RD_ACK;
          end else if (wr_s && rd_s) begin
            errCnt <= sat_inc(errCnt);
            state  <= ERR_WAIT;
          end
        end
        WR_ACK: begin
          if (!wr_s) begin
            ack   <= 1'b0;
            state <= IDLE;
          end
        end
        RD_ACK: begin
          if (!rd_s) begin
            ack     <= 1'b0;
            outEn   <= 1'b0;
            outData <= '0;
            state   <= IDLE;
          end
        end
        ERR_WAIT: begin
          if (!wr_s && !rd_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
